// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: RISC-V control-flow opcodes and the fetch FIFO entry layout.
// The entry fields are fixed at FETCH_XLEN bits, so the fetch unit is intended for size == FETCH_XLEN.
package fetch_pc_unit_pkg;

   localparam int FETCH_XLEN = 32;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] instr;
      logic [FETCH_XLEN-1:0] pc;
      logic                  pred_taken;
      logic [FETCH_XLEN-1:0] pred_target;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_pc_unit_imm_decoder.sv
// Early immediate decoder: extracts the sign-extended J/B-type offset of an arriving instruction
// so the fetch unit can form a predicted target in the response cycle.
module early_stage_immediate_decoder
   import fetch_pc_unit_pkg::*;
#(
   parameter int size = 32
) (
   input  logic [size-1:0] i_instr,
   output logic [size-1:0] o_imm,
   output logic            o_is_jal,
   output logic            o_is_branch
);

   logic [6:0]  w_opcode;
   logic [20:0] w_j_imm;
   logic [12:0] w_b_imm;

   assign w_opcode = i_instr[6:0];
   assign w_j_imm  = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
   assign w_b_imm  = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};

   assign o_is_jal    = (w_opcode == OPC_JAL);
   assign o_is_branch = (w_opcode == OPC_BRANCH);

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      o_imm = '0;
      if (o_is_jal) begin
         o_imm = {{(size-21){w_j_imm[20]}}, w_j_imm};
      end else if (o_is_branch) begin
         o_imm = {{(size-13){w_b_imm[12]}}, w_b_imm};
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: sequential/predicted fetch addressing with one outstanding request
// and a 2-entry instruction FIFO feeding decode; redirects flush everything in flight.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int              size     = 32,
   parameter logic [size-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_o,
   output logic [size-1:0] imem_addr_o,
   input  logic [size-1:0] imem_rdata_i,
   input  logic            redirect_i,
   input  logic [size-1:0] redirect_pc_i,
   output logic            if_valid_o,
   input  logic            id_ready_i,
   output logic [size-1:0] if_instr_o,
   output logic [size-1:0] if_pc_o,
   output logic [size-1:0] if_pred_target_o,
   output logic            if_pred_taken_o
);

   logic [size-1:0] r_pc;
   logic            r_resp_pending;
   logic [size-1:0] r_resp_pc;

   fetch_entry_t    r_fifo [2];
   logic            r_rd_ptr;
   logic            r_wr_ptr;
   logic [1:0]      r_count;

   logic [size-1:0] w_imm;
   logic            w_is_jal;
   logic            w_is_branch;
   logic            w_pop;
   logic            w_push;
   logic            w_taken;
   logic            w_push_taken;
   logic [size-1:0] w_target;
   logic [size-1:0] w_seq_pc;
   logic [2:0]      w_inflight;
   fetch_entry_t    w_entry;
   fetch_entry_t    w_head;

   early_stage_immediate_decoder #(
      .size (size)
   ) u_imm_dec (
      .i_instr     (imem_rdata_i),
      .o_imm       (w_imm),
      .o_is_jal    (w_is_jal),
      .o_is_branch (w_is_branch)
   );

   assign if_valid_o   = (r_count != 2'd0);
   assign w_pop        = if_valid_o & id_ready_i;
   assign w_push       = r_resp_pending & ~redirect_i;
   assign w_taken      = w_is_jal | (w_is_branch & imem_rdata_i[31]);
   assign w_push_taken = w_push & w_taken;
   assign w_target     = r_resp_pc + w_imm;
   assign w_seq_pc     = r_resp_pc + size'(4);

   // Entries already held, plus the one in flight, minus the one leaving this cycle.
   assign w_inflight = {1'b0, r_count} + {2'b00, r_resp_pending} - {2'b00, w_pop};
   assign imem_req_o = redirect_i | (w_inflight < 3'd2);

   always_comb begin
      imem_addr_o = r_pc;
      if (redirect_i) begin
         imem_addr_o = redirect_pc_i;
      end else if (w_push_taken) begin
         imem_addr_o = w_target;
      end
   end

   always_comb begin
      w_entry             = '0;
      w_entry.instr       = imem_rdata_i;
      w_entry.pc          = r_resp_pc;
      w_entry.pred_taken  = w_taken;
      w_entry.pred_target = w_taken ? w_target : w_seq_pc;
   end

   // NOTE: all state below is written with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc           <= RESET_PC;
         r_resp_pending <= 1'b0;
         r_resp_pc      <= '0;
      end else begin
         r_resp_pending <= imem_req_o;
         r_resp_pc      <= imem_addr_o;
         if (imem_req_o) begin
            r_pc <= imem_addr_o + size'(4);
         end else if (w_push_taken) begin
            r_pc <= w_target;
         end
      end
   end

   // NOTE: FIFO storage is reset too, so the head outputs read as zero while reset is held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            r_fifo[i] <= '0;
         end
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (redirect_i) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_entry;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign w_head           = r_fifo[r_rd_ptr];
   assign if_instr_o       = w_head.instr;
   assign if_pc_o          = w_head.pc;
   assign if_pred_taken_o  = w_head.pred_taken;
   assign if_pred_target_o = w_head.pred_target;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit: a one-cycle-latency instruction memory
// model plus hand-computed expectations for each cycle of interest.
module tb_fetch_pc_unit;

   localparam logic [31:0] INSN_ADDI   = 32'h0000_0013;
   localparam logic [31:0] INSN_JAL    = 32'h1000_006F;
   localparam logic [31:0] INSN_BEQ_M8 = 32'hFE00_0CE3;
   localparam logic [31:0] INSN_BEQ_P8 = 32'h0000_0463;

   logic        clk;
   logic        reset;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        if_valid_o;
   logic        id_ready_i;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_pred_target_o;
   logic        if_pred_taken_o;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic mode     = 1'b0;

   fetch_pc_unit #(
      .size     (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_rdata_i     (imem_rdata_i),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .if_valid_o       (if_valid_o),
      .id_ready_i       (id_ready_i),
      .if_instr_o       (if_instr_o),
      .if_pc_o          (if_pc_o),
      .if_pred_target_o (if_pred_target_o),
      .if_pred_taken_o  (if_pred_taken_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program image: mode 0 is a pure ADDI stream, mode 1 adds the control-flow cases.
   function automatic logic [31:0] imem_word(input logic [31:0] addr);
      logic [31:0] w;
      w = INSN_ADDI;
      if (mode) begin
         case (addr)
            32'h08:  w = INSN_JAL;
            32'h20:  w = INSN_BEQ_M8;
            32'h24:  w = INSN_BEQ_P8;
            default: w = INSN_ADDI;
         endcase
      end
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; the memory answers a request accepted at this edge one cycle later.
   task automatic tick();
      logic        cap_req;
      logic [31:0] cap_addr;
      cap_req  = imem_req_o;
      cap_addr = imem_addr_o;
      @(posedge clk);
      #1;
      imem_rdata_i = cap_req ? imem_word(cap_addr) : 32'h0;
   endtask

   task automatic cyc(input logic ready, input logic redir, input logic [31:0] rpc);
      tick();
      id_ready_i    = ready;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      #1;
   endtask

   initial begin
      reset         = 1'b0;
      id_ready_i    = 1'b1;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      imem_rdata_i  = 32'h0;

      repeat (3) tick();
      #1;
      check("rst_valid",  32'(if_valid_o), 32'h0);
      check("rst_instr",  if_instr_o, 32'h0);
      check("rst_pc",     if_pc_o, 32'h0);
      check("rst_target", if_pred_target_o, 32'h0);
      check("rst_taken",  32'(if_pred_taken_o), 32'h0);

      // Sequential ADDI stream after reset release.
      tick();
      reset = 1'b1;
      #1;
      check("c0_req",   32'(imem_req_o), 32'h1);
      check("c0_addr",  imem_addr_o, 32'h0);
      cyc(1'b1, 1'b0, 32'h0);
      check("c1_addr",  imem_addr_o, 32'h4);
      check("c1_valid", 32'(if_valid_o), 32'h0);
      cyc(1'b1, 1'b0, 32'h0);
      check("c2_valid", 32'(if_valid_o), 32'h1);
      check("c2_pc",    if_pc_o, 32'h0);
      check("c2_addr",  imem_addr_o, 32'h8);
      cyc(1'b1, 1'b0, 32'h0);
      check("c3_pc",    if_pc_o, 32'h4);
      check("c3_addr",  imem_addr_o, 32'hC);
      cyc(1'b1, 1'b0, 32'h0);
      check("c4_pc",    if_pc_o, 32'h8);

      // Decode stalls five cycles: FIFO fills, requests stop.
      cyc(1'b0, 1'b0, 32'h0);
      check("stall5_pc",  if_pc_o, 32'hC);
      check("stall5_req", 32'(imem_req_o), 32'h0);
      repeat (4) cyc(1'b0, 1'b0, 32'h0);
      check("stall9_req",   32'(imem_req_o), 32'h0);
      check("stall9_valid", 32'(if_valid_o), 32'h1);
      check("stall9_pc",    if_pc_o, 32'hC);
      cyc(1'b1, 1'b0, 32'h0);
      check("res10_pc",   if_pc_o, 32'hC);
      check("res10_addr", imem_addr_o, 32'h14);
      cyc(1'b1, 1'b0, 32'h0);
      check("res11_pc", if_pc_o, 32'h10);
      cyc(1'b1, 1'b0, 32'h0);
      check("res12_pc", if_pc_o, 32'h14);
      cyc(1'b1, 1'b0, 32'h0);
      check("res13_pc", if_pc_o, 32'h18);

      // Redirect while a response arrives and decode is stalled.
      cyc(1'b0, 1'b1, 32'h400);
      check("rd_valid", 32'(if_valid_o), 32'h1);
      check("rd_pc",    if_pc_o, 32'h1C);
      check("rd_req",   32'(imem_req_o), 32'h1);
      check("rd_addr",  imem_addr_o, 32'h400);
      cyc(1'b0, 1'b0, 32'h0);
      check("rd1_valid", 32'(if_valid_o), 32'h0);
      check("rd1_addr",  imem_addr_o, 32'h404);
      cyc(1'b1, 1'b0, 32'h0);
      check("rd2_pc",   if_pc_o, 32'h400);
      check("rd2_addr", imem_addr_o, 32'h408);

      // PC wrap at the top of the address space.
      cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
      check("wrap_rd_addr", imem_addr_o, 32'hFFFF_FFFC);
      cyc(1'b1, 1'b0, 32'h0);
      check("wrap_addr", imem_addr_o, 32'h0);
      cyc(1'b1, 1'b0, 32'h0);
      check("wrap_pc",     if_pc_o, 32'hFFFF_FFFC);
      check("wrap_target", if_pred_target_o, 32'h0);
      check("wrap_taken",  32'(if_pred_taken_o), 32'h0);

      // Reset asserted mid-stream clears outputs without waiting for a clock edge.
      #2;
      reset = 1'b0;
      #1;
      check("mrst_valid", 32'(if_valid_o), 32'h0);
      check("mrst_pc",    if_pc_o, 32'h0);
      check("mrst_instr", if_instr_o, 32'h0);
      mode = 1'b1;
      repeat (2) tick();
      tick();
      reset = 1'b1;
      #1;
      check("b0_req",   32'(imem_req_o), 32'h1);
      check("b0_addr",  imem_addr_o, 32'h0);
      check("b0_valid", 32'(if_valid_o), 32'h0);

      // JAL +0x100 at 0x8: zero-bubble redirect of the fetch stream.
      cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 32'h0);
      check("jal_req",  32'(imem_req_o), 32'h1);
      check("jal_addr", imem_addr_o, 32'h108);
      cyc(1'b1, 1'b0, 32'h0);
      check("jal_pc",     if_pc_o, 32'h8);
      check("jal_instr",  if_instr_o, INSN_JAL);
      check("jal_taken",  32'(if_pred_taken_o), 32'h1);
      check("jal_target", if_pred_target_o, 32'h108);
      check("jal_next",   imem_addr_o, 32'h10C);
      cyc(1'b1, 1'b0, 32'h0);
      check("jal_nobubble", if_pc_o, 32'h108);

      // Backward branch at 0x20 predicted taken to 0x18.
      cyc(1'b1, 1'b1, 32'h20);
      check("bwd_rd_addr", imem_addr_o, 32'h20);
      cyc(1'b1, 1'b0, 32'h0);
      check("bwd_addr",  imem_addr_o, 32'h18);
      check("bwd_valid", 32'(if_valid_o), 32'h0);
      cyc(1'b1, 1'b0, 32'h0);
      check("bwd_pc",     if_pc_o, 32'h20);
      check("bwd_taken",  32'(if_pred_taken_o), 32'h1);
      check("bwd_target", if_pred_target_o, 32'h18);
      check("bwd_next",   imem_addr_o, 32'h1C);

      // Forward branch at 0x24 predicted not taken.
      cyc(1'b1, 1'b1, 32'h24);
      check("fwd_rd_addr", imem_addr_o, 32'h24);
      cyc(1'b1, 1'b0, 32'h0);
      check("fwd_addr", imem_addr_o, 32'h28);
      cyc(1'b1, 1'b0, 32'h0);
      check("fwd_pc",     if_pc_o, 32'h24);
      check("fwd_instr",  if_instr_o, INSN_BEQ_P8);
      check("fwd_taken",  32'(if_pred_taken_o), 32'h0);
      check("fwd_target", if_pred_target_o, 32'h28);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter size, 32, datapath/address width.
REQ-002 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req_o  out  1  fetch request this cycle.
REQ-006 SHALL have port imem_addr_o  out  size  fetch address; valid when imem_req_o=1.
REQ-007 SHALL have port imem_rdata_i  in  size  instruction; valid exactly one cycle after an accepted request.
REQ-008 SHALL have port redirect_i  in  1  flush from execute (mispredict/jump/trap).
REQ-009 SHALL have port redirect_pc_i  in  size  corrected fetch address.
REQ-010 SHALL have port if_valid_o  out  1  entry available to decode.
REQ-011 SHALL have port id_ready_i  in  1  decode accepts entry; pop when if_valid_o & id_ready_i.
REQ-012 SHALL have ports if_instr_o, if_pc_o, if_pred_target_o  out  size each  head-entry instruction, PC, predicted next PC.
REQ-013 SHALL have port if_pred_taken_o  out  1  head-entry predicted taken.

Function
REQ-014 SHALL hold pc_q (next sequential fetch address), resp_pending_q (request outstanding), resp_pc_q (its address), and a 2-entry FIFO of {instr, pc, pred_taken, pred_target}.
REQ-015 SHALL set imem_req_o=1 when redirect_i=1, else when occ + resp_pending_q - pop < 2 (occ = FIFO occupancy, pop = if_valid_o & id_ready_i).
REQ-016 SHALL push imem_rdata_i with resp_pc_q into FIFO when resp_pending_q=1 and redirect_i=0; push and pop in the same cycle SHALL both occur.
REQ-017 SHALL predict on the arriving instruction: opcode 1101111 (JAL) taken; opcode 1100011 (branch) taken iff bit31=1 (backward); all else not taken.
REQ-018 SHALL compute target = resp_pc_q + imm (modulo 2^size) and not-taken next PC = resp_pc_q + 4; pred_target stores whichever applies.
REQ-019 SHALL drive imem_addr_o by priority: redirect_i -> redirect_pc_i; push & taken -> target; else pc_q.
REQ-020 SHALL update pc_q to imem_addr_o + 4 when a request issues; to target when push & taken and no request issues; else hold.
REQ-021 SHALL, on redirect_i, clear FIFO, discard any arriving response, issue request at redirect_pc_i in the same cycle; redirect overrides push, prediction, and pop.
REQ-022 SHALL set resp_pending_q <= imem_req_o and resp_pc_q <= imem_addr_o each cycle.
REQ-023 SHALL give zero-bubble taken prediction: the request issued in the response cycle goes to target.
REQ-024 SHALL wrap PC arithmetic at 2^size without flag; no alignment check (bit0 of imm always 0).
REQ-025 SHALL drive if_valid_o = (occ != 0) from registers only, unaffected by redirect_i in the same cycle; data outputs show head entry.
REQ-026 SHALL never overflow FIFO: by REQ-015 a response always has a free slot.

Reset
REQ-027 SHALL, on reset low, asynchronously set pc_q=RESET_PC, resp_pending_q=0, resp_pc_q=0, FIFO empty, all FIFO storage 0.
REQ-028 SHALL present if_valid_o=0, if_pred_taken_o=0, if_instr_o/if_pc_o/if_pred_target_o=0 during reset.
REQ-029 SHALL issue first request (imem_req_o=1, imem_addr_o=RESET_PC) in first cycle after reset release; reset mid-operation SHALL abandon outstanding response.

Structure
REQ-030 SHALL place opcode constants OPC_JAL, OPC_BRANCH and typedef fetch_entry_t {instr, pc, pred_taken, pred_target} in the shared fetch-stage package.
REQ-031 SHALL instantiate early_stage_immediate_decoder (size=size) on imem_rdata_i as its only sub-module; FIFO SHALL be inline.

Verification
REQ-032 Reset release, id_ready_i=1, sequential ADDI stream -> addresses 0,4,8,12 on consecutive cycles; if_valid_o from cycle 2; if_pc_o 0,4,8.
REQ-033 JAL imm=+0x100 at PC 0x8 -> next imem_addr_o=0x108 in response cycle; entry pred_taken=1, pred_target=0x108; no bubble.
REQ-034 BEQ imm=-8 at 0x20 -> fetch 0x18 taken; BEQ imm=+8 at 0x24 -> fetch 0x28, pred_taken=0, pred_target=0x28.
REQ-035 id_ready_i=0 for 5 cycles -> occ reaches 2, imem_req_o=0, no entry lost/duplicated; resume yields in-order PCs.
REQ-036 redirect_i=1, redirect_pc_i=0x400 while FIFO full and response arriving -> FIFO empty next cycle, imem_addr_o=0x400 same cycle, next if_pc_o=0x400.
REQ-037 pc_q=0xFFFF_FFFC sequential -> next address 0x0000_0000; reset asserted mid-stream -> outputs zero immediately, restart at RESET_PC.
